// File: rtl/top_k_pkg.sv
// Shared types and helpers for the streaming top-K selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package top_k_pkg;

  // Frame phases: accepting samples, then draining ranked results.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Width of a rank number for k tracked ranks, never below one bit.
  function automatic int rank_w(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/top_k_slot.sv
// One cell of the sorted top-K array: value, in-frame position and valid flag.
// Latency: load/shift take effect on the next rising clk edge.
// Backpressure: none; the parent decides when the cell loads, shifts or holds.
// Ports: clr empties the cell; load_din captures {din, pos}; shift_in copies the
// cell above (up_*); ge flags a valid held value >= din, so it keeps its rank.
module top_k_slot #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load_din,
  input  logic              shift_in,
  input  logic [DATA_W-1:0] din,
  input  logic [IDX_W-1:0]  pos,
  input  logic [DATA_W-1:0] up_data,
  input  logic [IDX_W-1:0]  up_idx,
  input  logic              up_valid,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              ge
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      data  <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load_din) begin
      data  <= din;
      idx   <= pos;
      valid <= 1'b1;
    end else if (shift_in) begin
      data  <= up_data;
      idx   <= up_idx;
      valid <= up_valid;
    end
  end

  // Equal counts as "stays": an earlier sample outranks an equal later one.
  assign ge = valid && (data >= din);

endmodule

// File: rtl/top_k_finder.sv
// Streaming top-K selector: keeps the K largest samples of a frame (with their
// positions) sorted, then drains them rank 0 first on a valid/ready stream.
// Latency: one sample per cycle in; rank 0 valid the cycle after the last sample.
// Backpressure: din_ready low while draining; dout_* held while dout_ready is low.
// Ports: din/din_valid/din_last/din_ready sample stream in;
//        dout_data/idx/rank/last/valid/ready ranked stream out.
// Option: TOP_K_DISTINCT_EN drops samples equal to any held value.
module top_k_finder
  import top_k_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 4,
  parameter int IDX_W  = 8,
  parameter int RANK_W = rank_w(K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [IDX_W-1:0]  dout_idx,
  output logic [RANK_W-1:0] dout_rank,
  output logic              dout_last,
  output logic              dout_valid,
  input  logic              dout_ready
);

  state_t             state;
  logic [RANK_W-1:0]  r_q;
  logic [IDX_W-1:0]   pos_q;

  logic [DATA_W-1:0]  s_data [K];
  logic [IDX_W-1:0]   s_idx  [K];
  logic [K-1:0]       s_valid;
  logic [K-1:0]       s_ge;
  logic [K-1:0]       s_load;
  logic [K-1:0]       s_shift;
  logic [K:0]         v_ext;

  logic accept, ins, out_hs, drain_done;

  assign din_ready  = (state != DRAIN);
  assign accept     = din_valid && din_ready;
  assign dout_valid = (state == DRAIN);
  assign out_hs     = dout_valid && dout_ready;
  assign drain_done = out_hs && dout_last;

`ifdef TOP_K_DISTINCT_EN
  logic dup;
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (s_valid[i] && (s_data[i] == din)) dup = 1'b1;
    end
  end
  assign ins = accept && !dup;
`else
  assign ins = accept;
`endif

  // The array is sorted with valid entries packed at the top, so s_ge is a
  // prefix mask: the first cell without ge is the insert slot, the ones below
  // it shift down, and the bottom entry falls off. All-ge means the sample drops.
  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign s_load[i]  = ins && !s_ge[i];
      assign s_shift[i] = 1'b0;
      top_k_slot #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_slot (
        .clk(clk), .rst(rst), .clr(drain_done),
        .load_din(s_load[i]), .shift_in(s_shift[i]),
        .din(din), .pos(pos_q),
        .up_data(din), .up_idx(pos_q), .up_valid(1'b0),
        .data(s_data[i]), .idx(s_idx[i]), .valid(s_valid[i]), .ge(s_ge[i])
      );
    end else begin : g_body
      assign s_load[i]  = ins && !s_ge[i] && s_ge[i-1];
      assign s_shift[i] = ins && !s_ge[i] && !s_ge[i-1];
      top_k_slot #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_slot (
        .clk(clk), .rst(rst), .clr(drain_done),
        .load_din(s_load[i]), .shift_in(s_shift[i]),
        .din(din), .pos(pos_q),
        .up_data(s_data[i-1]), .up_idx(s_idx[i-1]), .up_valid(s_valid[i-1]),
        .data(s_data[i]), .idx(s_idx[i]), .valid(s_valid[i]), .ge(s_ge[i])
      );
    end
  end

  // Entry r is the last one when the entry after it is invalid or absent.
  assign v_ext     = {1'b0, s_valid} >> r_q;
  assign dout_last = dout_valid && !v_ext[1];
  assign dout_data = s_data[r_q];
  assign dout_idx  = s_idx[r_q];
  assign dout_rank = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r_q   <= '0;
      pos_q <= '0;
    end else begin
      // Saturating position: late samples still rank, all reported at max idx.
      if (accept && (pos_q != '1)) pos_q <= pos_q + 1'b1;
      case (state)
        IDLE:    if (accept) state <= din_last ? DRAIN : COLLECT;
        COLLECT: if (accept && din_last) state <= DRAIN;
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            r_q   <= '0;
            pos_q <= '0;
          end else if (out_hs) begin
            r_q <= r_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_k_finder.sv
// Directed bench for top_k_finder: main DUT (K=4, IDX_W=8) and a narrow-index
// DUT (K=4, IDX_W=2) for position saturation. Inputs driven 1 time unit after
// the rising edge, outputs sampled before the next edge.
module tb_top_k_finder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] din = '0;
  logic       din_valid = 1'b0, din_last = 1'b0, din_ready;
  logic [7:0] dout_data, dout_idx;
  logic [1:0] dout_rank;
  logic       dout_last, dout_valid, dout_ready = 1'b1;

  logic [7:0] din2 = '0;
  logic       din2_valid = 1'b0, din2_last = 1'b0, din2_ready;
  logic [7:0] dout2_data;
  logic [1:0] dout2_idx, dout2_rank;
  logic       dout2_last, dout2_valid, dout2_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  top_k_finder #(.DATA_W(8), .K(4), .IDX_W(8)) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .dout_data(dout_data), .dout_idx(dout_idx), .dout_rank(dout_rank),
    .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  top_k_finder #(.DATA_W(8), .K(4), .IDX_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .din(din2), .din_valid(din2_valid), .din_last(din2_last), .din_ready(din2_ready),
    .dout_data(dout2_data), .dout_idx(dout2_idx), .dout_rank(dout2_rank),
    .dout_last(dout2_last), .dout_valid(dout2_valid), .dout_ready(dout2_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for exactly one cycle (accepted since din_ready is high).
  task automatic send(input bit u, input int v, input bit last);
    if (u) begin
      din2 = v[7:0]; din2_valid = 1'b1; din2_last = last;
    end else begin
      din = v[7:0]; din_valid = 1'b1; din_last = last;
    end
    tick();
    din_valid = 1'b0; din_last = 1'b0;
    din2_valid = 1'b0; din2_last = 1'b0;
  endtask

  // Check the currently presented ranked entry, then let it handshake.
  task automatic expect_entry(input bit u, input string tag, input int rank,
                              input int d, input int i, input bit last);
    if (u) begin
      chk({tag, "_vld"},  dout2_valid, 1);
      chk({tag, "_dat"},  dout2_data,  d);
      chk({tag, "_idx"},  dout2_idx,   i);
      chk({tag, "_rank"}, dout2_rank,  rank);
      chk({tag, "_last"}, dout2_last,  last);
    end else begin
      chk({tag, "_vld"},  dout_valid, 1);
      chk({tag, "_dat"},  dout_data,  d);
      chk({tag, "_idx"},  dout_idx,   i);
      chk({tag, "_rank"}, dout_rank,  rank);
      chk({tag, "_last"}, dout_last,  last);
    end
    tick();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_dout_vld"}, dout_valid, 0);
    chk({tag, "_din_rdy"},  din_ready,  1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset values while reset is held.
    chk("rst_dout_vld",  dout_valid, 0);
    chk("rst_dout_last", dout_last,  0);
    chk("rst_dout_dat",  dout_data,  0);
    chk("rst_dout_idx",  dout_idx,   0);
    chk("rst_dout_rank", dout_rank,  0);
    chk("rst_din_rdy",   din_ready,  1);
    rst = 1'b0;
    tick();

    // Frame 3,9,1,7,9,2 with duplicate 9.
    send(0, 3, 0); send(0, 9, 0); send(0, 1, 0);
    send(0, 7, 0); send(0, 9, 0); send(0, 2, 1);
    chk("a_din_rdy_drain", din_ready, 0);
`ifdef TOP_K_DISTINCT_EN
    expect_entry(0, "a0", 0, 9, 1, 0);
    expect_entry(0, "a1", 1, 7, 3, 0);
    expect_entry(0, "a2", 2, 3, 0, 0);
    expect_entry(0, "a3", 3, 2, 5, 1);
`else
    expect_entry(0, "a0", 0, 9, 1, 0);
    expect_entry(0, "a1", 1, 9, 4, 0);
    expect_entry(0, "a2", 2, 7, 3, 0);
    expect_entry(0, "a3", 3, 3, 0, 1);
`endif
    expect_idle("a_end");

    // Two-sample frame: exactly two entries, then ready for input.
    send(0, 5, 0); send(0, 6, 1);
    expect_entry(0, "b0", 0, 6, 1, 0);
    expect_entry(0, "b1", 1, 5, 0, 1);
    expect_idle("b_end");

    // Single-sample frame of value 0.
    send(0, 0, 1);
    expect_entry(0, "c0", 0, 0, 0, 1);
    expect_idle("c_end");

    // Backpressure with rank 1 presented; din pulses must be ignored.
    send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 1);
    expect_entry(0, "d0", 0, 40, 3, 0);
    dout_ready = 1'b0;
    din = 8'd99; din_valid = 1'b1; din_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("d_hold_vld",  dout_valid, 1);
      chk("d_hold_dat",  dout_data,  30);
      chk("d_hold_idx",  dout_idx,   2);
      chk("d_hold_rank", dout_rank,  1);
      chk("d_hold_last", dout_last,  0);
      chk("d_hold_rdy",  din_ready,  0);
      tick();
    end
    din_valid = 1'b0; din_last = 1'b0;
    dout_ready = 1'b1;
    expect_entry(0, "d1", 1, 30, 2, 0);
    expect_entry(0, "d2", 2, 20, 1, 0);
    expect_entry(0, "d3", 3, 10, 0, 1);
    expect_idle("d_end");

    // Reset pulse mid-drain, after rank 0 has gone out.
    send(0, 1, 0); send(0, 2, 0); send(0, 3, 1);
    expect_entry(0, "e0", 0, 3, 2, 0);
    rst = 1'b1;
    #1;
    chk("e_rst_vld",  dout_valid, 0);
    chk("e_rst_last", dout_last,  0);
    chk("e_rst_dat",  dout_data,  0);
    chk("e_rst_idx",  dout_idx,   0);
    chk("e_rst_rank", dout_rank,  0);
    chk("e_rst_rdy",  din_ready,  1);
    tick();
    rst = 1'b0;
    tick();
    send(0, 4, 0); send(0, 8, 1);
    expect_entry(0, "f0", 0, 8, 1, 0);
    expect_entry(0, "f1", 1, 4, 0, 1);
    expect_idle("f_end");

    // Narrow index: positions saturate at 3.
    send(1, 1, 0); send(1, 1, 0); send(1, 1, 0);
    send(1, 1, 0); send(1, 1, 0); send(1, 20, 1);
`ifdef TOP_K_DISTINCT_EN
    expect_entry(1, "g0", 0, 20, 3, 0);
    expect_entry(1, "g1", 1, 1, 0, 1);
`else
    expect_entry(1, "g0", 0, 20, 3, 0);
    expect_entry(1, "g1", 1, 1, 0, 0);
    expect_entry(1, "g2", 2, 1, 1, 0);
    expect_entry(1, "g3", 3, 1, 2, 1);
`endif
    chk("g_end_vld", dout2_valid, 0);
    chk("g_end_rdy", din2_ready,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
